// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receiver with centre-of-bit sampling.
// The line is synchronised, a falling edge from idle starts a frame, each
// bit is sampled mid-period from a counter that reloads at every sample
// point, and a good frame produces a one-cycle rdata_ready pulse.
module uart_rx_core #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  output logic [7:0] rdata,
  output logic       rdata_ready,
  output logic       ferr,
  input  logic       rxd,
  input  logic       clk,
  input  logic       rstn
);

  localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic rxd_m;
  logic rxd_s;
  logic rxd_p;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       rdata_nxt;
  logic             ready_nxt;
  logic             ferr_nxt;

  // Two-flop synchroniser plus one history flop for edge detection; all
  // reset low so a line held low through reset is not seen as a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_m <= 1'b0;
      rxd_s <= 1'b0;
      rxd_p <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  // Receiver state, bit timing counter, shift register and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      rdata       <= '0;
      rdata_ready <= 1'b0;
      ferr        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shift       <= shift_nxt;
      rdata       <= rdata_nxt;
      rdata_ready <= ready_nxt;
      ferr        <= ferr_nxt;
    end
  end

  // Next-state logic: counter reloads at each sample point so timing error
  // never accumulates across a frame.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    rdata_nxt = rdata;
    ready_nxt = 1'b0;
    ferr_nxt  = ferr;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rxd_p && !rxd_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rxd_s) begin
            // Line went back high before mid-start: treat as a glitch.
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rxd_s;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rxd_s) begin
            rdata_nxt = shift;
            ready_nxt = 1'b1;
            ferr_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            // Bad stop bit: flag it and wait for the line to recover so a
            // break does not immediately start another frame.
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rxd_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: directed frames driven as a serial line, with
// expected bytes queued at send time and checked when rdata_ready pulses.
module tb_uart_rx_core;

  localparam int H       = 30;
  localparam int BIT_CYC = 2 * H;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd  = 1'b1;
  logic [7:0] rdata;
  logic       rdata_ready;
  logic       ferr;

  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  int         pulse_cnt = 0;
  int         last_pulse_cyc = 0;
  int         fall_cyc = 0;
  int         p0;
  logic       prev_ready = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] b96 = 8'h96;

  uart_rx_core #(H) dut (
    .rdata      (rdata),
    .rdata_ready(rdata_ready),
    .ferr       (ferr),
    .rxd        (rxd),
    .clk        (clk),
    .rstn       (rstn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one full 10-bit frame with no extra idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    rxd = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BIT_CYC);
    end
    rxd = stop_bit;
    idle(BIT_CYC);
  endtask

  // Scoreboard monitor: every pulse must be single-cycle and match the
  // oldest queued byte with ferr clear.
  always @(negedge clk) begin
    if (rdata_ready) begin
      pulse_cnt      <= pulse_cnt + 1;
      last_pulse_cyc <= cyc;
      check("pulse_width", int'(prev_ready), 0);
      check("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("rx_byte", int'(rdata), int'(mon_exp));
        check("rx_ferr", int'(ferr), 0);
      end
    end
    prev_ready <= rdata_ready;
  end

  initial begin
    #1000000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rxd  = 1'b1;
    rstn = 1'b0;
    idle(5);
    check("rst_rdata", int'(rdata), 0);
    check("rst_ready", int'(rdata_ready), 0);
    check("rst_ferr", int'(ferr), 0);
    rstn = 1'b1;
    idle(20);

    // Single byte with latency bound
    p0 = pulse_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(10);
    check("b55_count", pulse_cnt - p0, 1);
    check("b55_latency", int'((last_pulse_cyc - fall_cyc) >= 19 * H &&
                              (last_pulse_cyc - fall_cyc) <= 19 * H + 4), 1);
    check("b55_rdata", int'(rdata), 8'h55);
    check("b55_ferr", int'(ferr), 0);
    check("b55_queue", exp_q.size(), 0);

    // Back-to-back frames with zero idle time
    p0 = pulse_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA3);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA3, 1'b1);
    idle(10);
    check("b2b_count", pulse_cnt - p0, 3);
    check("b2b_queue", exp_q.size(), 0);
    check("b2b_rdata", int'(rdata), 8'hA3);

    // Framing error followed by a long break, then recovery
    p0 = pulse_cnt;
    send_frame(8'h3C, 1'b0);
    idle(5 * BIT_CYC);
    check("ferr_set", int'(ferr), 1);
    check("ferr_rdata_kept", int'(rdata), 8'hA3);
    check("ferr_no_pulse", pulse_cnt - p0, 0);
    rxd = 1'b1;
    idle(BIT_CYC);
    check("ferr_sticky", int'(ferr), 1);
    check("break_no_pulse", pulse_cnt - p0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(10);
    check("b81_count", pulse_cnt - p0, 1);
    check("b81_rdata", int'(rdata), 8'h81);
    check("b81_ferr_clr", int'(ferr), 0);

    // Short glitch on an idle line
    p0 = pulse_cnt;
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(100);
    check("glitch_no_pulse", pulse_cnt - p0, 0);
    check("glitch_ferr", int'(ferr), 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(10);
    check("b7e_count", pulse_cnt - p0, 1);
    check("b7e_rdata", int'(rdata), 8'h7E);

    // Reset in the middle of bit 4 of 0x96
    p0 = pulse_cnt;
    rxd = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rxd = b96[i];
      idle(BIT_CYC);
    end
    rxd = b96[4];
    idle(H);
    rstn = 1'b0;
    idle(3);
    check("midrst_rdata", int'(rdata), 0);
    check("midrst_ready", int'(rdata_ready), 0);
    check("midrst_ferr", int'(ferr), 0);
    rxd = 1'b1;
    idle(2);
    rstn = 1'b1;
    idle(22 * BIT_CYC);
    check("midrst_no_pulse", pulse_cnt - p0, 0);
    check("midrst_rdata_hold", int'(rdata), 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(10);
    check("b42_count", pulse_cnt - p0, 1);
    check("b42_rdata", int'(rdata), 8'h42);

    // Line held low across reset release, raised 10 cycles later
    rstn = 1'b0;
    rxd  = 1'b0;
    idle(5);
    p0 = pulse_cnt;
    rstn = 1'b1;
    idle(10);
    rxd = 1'b1;
    idle(22 * BIT_CYC);
    check("lowrst_no_pulse", pulse_cnt - p0, 0);
    check("lowrst_ferr", int'(ferr), 0);
    check("lowrst_rdata", int'(rdata), 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(10);
    check("b11_count", pulse_cnt - p0, 1);
    check("b11_rdata", int'(rdata), 8'h11);
    check("b11_ferr", int'(ferr), 0);

    check("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
